// File: rtl/rr_arbiter16_pkg.sv
// Shared definitions for the 16-way round-robin arbiter: sizes and FSM state encoding.
package rr_arbiter16_pkg;

    localparam int NREQ  = 16;
    localparam int IDX_W = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter16_dec4to16.sv
// 4-to-16 one-hot decoder with enable; all outputs low when en is low.
module dec4to16 (
    input  logic        en,
    input  logic [3:0]  w,
    output logic [15:0] y
);

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_dec
            assign y[gi] = en && (w == 4'(gi));
        end
    endgenerate

endmodule

// File: rtl/rr_arbiter16.sv
// Round-robin arbiter for 16 requesters: one grant per round, held until done,
// withdrawal or hold limit, followed by one idle bubble before the next round.
module rr_arbiter16
    import rr_arbiter16_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req,
    input  logic        done,
    output logic [15:0] gnt,
    output logic [3:0]  gnt_idx,
    output logic        gnt_valid
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   ptr_reg, ptr_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic [HOLD_W-1:0]  hold_reg, hold_next;

    logic [NREQ-1:0]    rot_req;
    logic [IDX_W-1:0]   win_idx;
    logic               win_found;
    logic               grant_end;

    // rot_req[k] is the requester k positions past the priority pointer.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_rot
            assign rot_req[gi] = req[ptr_reg + IDX_W'(gi)];
        end
    endgenerate

    // Lowest rotated offset wins; scanning downward lets the nearest one overwrite.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_reg;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot_req[k]) begin
                win_found = 1'b1;
                win_idx   = ptr_reg + IDX_W'(k);
            end
        end
    end

    assign grant_end = done || !req[idx_reg] || (hold_reg == HOLD_W'(MAX_HOLD));

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        idx_next   = idx_reg;
        hold_next  = hold_reg;
        case (state_reg)
            ST_IDLE: begin
                if (win_found) begin
                    idx_next   = win_idx;
                    hold_next  = HOLD_W'(1);
                    state_next = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (grant_end) begin
                    ptr_next   = idx_reg + IDX_W'(1);
                    hold_next  = '0;
                    state_next = ST_IDLE;
                end else begin
                    hold_next  = hold_reg + HOLD_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= '0;
            idx_reg   <= '0;
            hold_reg  <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            idx_reg   <= idx_next;
            hold_reg  <= hold_next;
        end
    end

    assign gnt_valid = (state_reg == ST_GRANT);
    assign gnt_idx   = idx_reg;

    dec4to16 u_dec (
        .en (gnt_valid),
        .w  (idx_reg),
        .y  (gnt)
    );

endmodule

// File: tb/tb_rr_arbiter16.sv
// Self-checking bench for rr_arbiter16 (MAX_HOLD = 4): vector table plus hand-written
// multi-cycle sequences, all checked through an expected-result queue.
module tb_rr_arbiter16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] req = 16'h0000;
    logic        done = 1'b0;
    logic [15:0] gnt;
    logic [3:0]  gnt_idx;
    logic        gnt_valid;

    rr_arbiter16 #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always #5 clk = ~clk;

    // One record per clock: inputs for the cycle, outputs required after its edge.
    typedef struct packed {
        logic        rst;
        logic [15:0] req;
        logic        done;
        logic        valid;
        logic [3:0]  idx;
    } vec_t;

    typedef struct packed {
        logic [15:0] gnt;
        logic        valid;
        logic [3:0]  idx;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    function automatic vec_t mk(input logic r, input logic [15:0] q, input logic d,
                                input logic v, input logic [3:0] i);
        vec_t t;
        t.rst = r; t.req = q; t.done = d; t.valid = v; t.idx = i;
        return t;
    endfunction

    task automatic step(input vec_t t, input string name);
        exp_t e;
        exp_t got;
        logic [15:0] one;
        @(negedge clk);
        rst  = t.rst;
        req  = t.req;
        done = t.done;
        one  = 16'h0001;
        e.gnt   = t.valid ? (one << t.idx) : 16'h0000;
        e.valid = t.valid;
        e.idx   = t.idx;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        got = exp_q.pop_front();
        total++;
        if (gnt !== got.gnt || gnt_valid !== got.valid || gnt_idx !== got.idx) begin
            bad++;
            $display("FAIL %s cyc=%0d: got gnt=%h valid=%b idx=%0d, required gnt=%h valid=%b idx=%0d",
                     name, cyc, gnt, gnt_valid, gnt_idx, got.gnt, got.valid, got.idx);
        end else begin
            $display("ok   %s cyc=%0d rst=%b req=%h done=%b -> gnt=%h valid=%b idx=%0d",
                     name, cyc, t.rst, t.req, t.done, gnt, gnt_valid, gnt_idx);
        end
    endtask

    initial begin
        // Reset with all requests high, then idle.
        tbl.push_back(mk(1, 16'hFFFF, 0, 0, 0));
        tbl.push_back(mk(1, 16'hFFFF, 0, 0, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 16'h0000, 0, 0, 0));
        // Single requester 5: four grant cycles, one bubble, repeat.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 16'h0020, 0, 1, 5));
            tbl.push_back(mk(0, 16'h0020, 0, 0, 5));
        end
        tbl.push_back(mk(0, 16'h0000, 0, 0, 5));
        // Rotation 0 -> 15 -> 0 -> 15; done in an IDLE cycle must not block the grant.
        tbl.push_back(mk(1, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(0, 16'h8001, 0, 1, 0));
        tbl.push_back(mk(0, 16'h8001, 1, 0, 0));
        tbl.push_back(mk(0, 16'h8001, 1, 1, 15));
        tbl.push_back(mk(0, 16'h8001, 1, 0, 15));
        tbl.push_back(mk(0, 16'h8001, 0, 1, 0));
        tbl.push_back(mk(0, 16'h8001, 1, 0, 0));
        tbl.push_back(mk(0, 16'h8001, 0, 1, 15));
        tbl.push_back(mk(0, 16'h8001, 1, 0, 15));
        tbl.push_back(mk(0, 16'h0000, 0, 0, 15));

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], "table");

        // Withdrawal: bit 3 drops on its second grant cycle, pointer moves to 4 so bit 0 wins.
        step(mk(1, 16'h0000, 0, 0, 0),  "wd_reset");
        step(mk(0, 16'h0008, 0, 1, 3),  "wd_grant1");
        step(mk(0, 16'h0008, 0, 1, 3),  "wd_grant2");
        step(mk(0, 16'h0001, 0, 0, 3),  "wd_drop");
        step(mk(0, 16'h0009, 0, 1, 0),  "wd_next");
        step(mk(0, 16'h0009, 1, 0, 0),  "wd_done");

        // Simultaneous done and hold limit on requester 6: one exit, pointer lands on 7.
        for (int i = 0; i < 4; i++) step(mk(0, 16'h0040, 0, 1, 6), "sim_hold");
        step(mk(0, 16'h0040, 1, 0, 6),  "sim_exit");
        step(mk(0, 16'h01C0, 0, 1, 7),  "sim_ptr");
        step(mk(0, 16'h01C0, 1, 0, 7),  "sim_done");

        // Reset mid-grant of requester 10, then restart from requester 0.
        step(mk(0, 16'h0400, 0, 1, 10), "mr_grant1");
        step(mk(0, 16'h0400, 0, 1, 10), "mr_grant2");
        step(mk(1, 16'h0400, 0, 0, 0),  "mr_reset");
        step(mk(0, 16'hFFFF, 0, 1, 0),  "mr_first");
        step(mk(0, 16'hFFFF, 1, 0, 0),  "mr_done");

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
